// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default widths for the timer controller
// Contents:
//   state_t      : FSM state encoding (IDLE=00, RUN=01, PAUSED=10, DONE=11)
//   DEF_WIDTH    : default counter width
//   DEF_PRESC_W  : default prescaler width
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/up_counter_ld.sv
// rtl/up_counter_ld.sv - loadable up-counter with terminal-value flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : increment by one
//   ld         : load d (priority over en)
//   d          : load value
//   q          : counter value (registered)
//   at_max     : q equals all-ones
module up_counter_ld #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             at_max
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

    assign at_max = (q == '1);

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable timer: start/stop/pause, prescaler, one-shot or auto-reload
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : start with reload from IDLE/DONE, resume from PAUSED
//   stop         : abort to IDLE (highest priority)
//   pause        : freeze in PAUSED
//   load_val     : start value, latched on start from IDLE/DONE
//   prescale     : step every (prescale+1) RUN cycles, latched with load_val
//   auto_reload  : 1 = periodic, 0 = one-shot, latched with load_val
//   irq_ack      : clears irq (a simultaneous wrap wins)
//   count        : counter value
//   state        : IDLE=00, RUN=01, PAUSED=10, DONE=11
//   busy         : state is RUN or PAUSED
//   tc           : one-cycle pulse after each wrap
//   irq          : sticky interrupt
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               auto_reload,
    input  logic               irq_ack,
    output logic [WIDTH-1:0]   count,
    output logic [1:0]         state,
    output logic               busy,
    output logic               tc,
    output logic               irq
);

    state_t             state_q;
    logic               busy_q;
    logic               tc_q;
    logic               irq_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] cfg_presc;
    logic [WIDTH-1:0]   cfg_load;
    logic               cfg_auto;

    logic               cnt_ld;
    logic               cnt_en;
    logic [WIDTH-1:0]   cnt_d;
    logic               at_max;
    logic               step;
    logic               wrap;

    // Counter control decode; the counter register itself lives in up_counter_ld.
    // stop clears the count by loading zero.
    always_comb begin
        cnt_ld = 1'b0;
        cnt_en = 1'b0;
        cnt_d  = cfg_load;
        step   = 1'b0;
        wrap   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    cnt_ld = 1'b1;
                    cnt_d  = '0;
                end else if (start) begin
                    cnt_ld = 1'b1;
                    cnt_d  = load_val;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    cnt_ld = 1'b1;
                    cnt_d  = '0;
                end else if (!pause) begin
                    step = (presc_q == cfg_presc);
                    if (step) begin
                        if (at_max) begin
                            wrap   = 1'b1;
                            cnt_ld = cfg_auto;  // one-shot holds MAX
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    cnt_ld = 1'b1;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    up_counter_ld #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cnt_en),
        .ld     (cnt_ld),
        .d      (cnt_d),
        .q      (count),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            tc_q      <= 1'b0;
            irq_q     <= 1'b0;
            presc_q   <= '0;
            cfg_presc <= '0;
            cfg_load  <= '0;
            cfg_auto  <= 1'b0;
        end else begin
            tc_q <= wrap;
            if (wrap) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // pause has no meaning here, so start still proceeds under it
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        presc_q   <= '0;
                        cfg_load  <= load_val;
                        cfg_presc <= prescale;
                        cfg_auto  <= auto_reload;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (pause) begin
                        state_q <= ST_PAUSED;
                    end else if (step) begin
                        presc_q <= '0;
                        if (wrap && !cfg_auto) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        presc_q <= presc_q + PRESC_W'(1);
                    end
                end
                ST_PAUSED: begin
                    // prescaler stays frozen so resume continues the partial period
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!pause && start) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign irq   = irq_q;

endmodule
